// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and helpers for the 4-digit scan controller.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [1:0] idx;
        logic       wrap;
    } next_digit_t;

    // First set bit strictly above cur, wrapping through 0; wrap flags a frame boundary.
    function automatic next_digit_t next_digit(input logic [3:0] mask, input logic [1:0] cur);
        next_digit_t r;
        logic        found;
        logic [1:0]  cand;
        r.idx  = cur;
        r.wrap = 1'b1;
        found  = 1'b0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            cand = cur + 2'(k);
            if (!found && mask[cand]) begin
                found = 1'b1;
                r.idx = cand;
            end
        end
        r.wrap = (r.idx <= cur);
        return r;
    endfunction

    function automatic logic [3:0] nibble_of(input logic [15:0] d, input logic [1:0] idx);
        return d[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_slot_timer.sv
// Per-slot cycle counter; blank is a registered copy of (cnt < BLANK_CYCLES).
module slot_timer #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 1,
    localparam int CW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] cnt,
    output logic          slot_end,
    output logic          blank
);

    localparam logic [CW-1:0] LAST    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_next;

    assign slot_end = (cnt == LAST);
    assign cnt_next = slot_end ? '0 : cnt + CW'(1);

    // clear parks the counter at slot start, which is always a blanked cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= '0;
            blank <= 1'b1;
        end else if (advance) begin
            cnt   <= cnt_next;
            blank <= (cnt_next < BLANK_W);
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller driving an active-low 2-to-4 decoder.
module digit_scan_ctrl
    import display_pkg::*;
#(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  digit_mask,
    input  logic [15:0] data,
    output logic [1:0]  sel,
    output logic        enable_n,
    output logic [3:0]  nibble,
    output logic        frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    scan_state_t   state, state_d;
    logic [15:0]   shadow, shadow_d;
    logic [1:0]    sel_d;
    logic [3:0]    nibble_d;
    logic          frame_d;
    logic [CW-1:0] cnt;
    logic          slot_end;
    logic          clear;
    logic          advance;
    next_digit_t   nd;

    always_comb begin
        state_d  = state;
        sel_d    = sel;
        nibble_d = nibble;
        shadow_d = shadow;
        frame_d  = 1'b0;
        nd       = next_digit(digit_mask, sel);
        case (state)
            IDLE: begin
                if (run && digit_mask != 4'b0000) begin
                    // Searching above index 3 yields the lowest set bit.
                    nd       = next_digit(digit_mask, 2'd3);
                    state_d  = SCAN;
                    shadow_d = data;
                    sel_d    = nd.idx;
                    nibble_d = nibble_of(data, nd.idx);
                end
            end
            SCAN: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (slot_end) begin
                    if (digit_mask == 4'b0000) begin
                        state_d = IDLE;
                    end else begin
                        sel_d = nd.idx;
                        if (nd.wrap) begin
                            shadow_d = data;
                            nibble_d = nibble_of(data, nd.idx);
                            frame_d  = 1'b1;
                        end else begin
                            nibble_d = nibble_of(shadow, nd.idx);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clear   = (state == IDLE) || (state_d != SCAN);
    assign advance = (state == SCAN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 2'd0;
            nibble     <= 4'd0;
            shadow     <= 16'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            sel        <= sel_d;
            nibble     <= nibble_d;
            shadow     <= shadow_d;
            frame_done <= frame_d;
        end
    end

    // The timer's blank flag doubles as the registered decoder enable.
    slot_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .advance  (advance),
        .cnt      (cnt),
        .slot_end (slot_end),
        .blank    (enable_n)
    );

    // Every slot opens blanked, so the decoder never sees a live select change.
    always_ff @(posedge clk) begin
        if (!rst && state == SCAN && cnt == '0) begin
            assert (enable_n);
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomized scoreboard bench for digit_scan_ctrl against a slot-level reference model.
module tb_digit_scan_ctrl;

    localparam int P = 4;
    localparam int B = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  digit_mask;
    logic [15:0] data;
    logic [1:0]  sel;
    logic        enable_n;
    logic [3:0]  nibble;
    logic        frame_done;

    typedef struct packed {
        logic [1:0] sel;
        logic       en_n;
        logic [3:0] nib;
        logic       fd;
    } exp_t;

    exp_t  q[$];
    string tq[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: which digit is lit, how far into its slot, and the frame snapshot.
    bit          m_active = 0;
    int          m_digit  = 0;
    int          m_pos    = 0;
    logic [15:0] m_frame  = 16'h0;
    logic [1:0]  m_sel    = 2'd0;
    logic [3:0]  m_nib    = 4'd0;
    bit          m_fd     = 0;

    digit_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .digit_mask (digit_mask),
        .data       (data),
        .sel        (sel),
        .enable_n   (enable_n),
        .nibble     (nibble),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int first_set_from(input logic [3:0] m, input int start);
        for (int k = 0; k < 4; k++) begin
            if (m[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit ru, input logic [3:0] m, input logic [15:0] d);
        int nd;
        if (r) begin
            m_active = 0; m_digit = 0; m_pos = 0; m_frame = 16'h0;
            m_sel = 2'd0; m_nib = 4'd0; m_fd = 0;
        end else begin
            m_fd = 0;
            if (!m_active) begin
                if (ru && m != 4'b0000) begin
                    m_active = 1;
                    m_digit  = first_set_from(m, 0);
                    m_frame  = d;
                    m_pos    = 0;
                end
            end else if (!ru) begin
                m_active = 0;
            end else if (m_pos == P - 1) begin
                if (m == 4'b0000) begin
                    m_active = 0;
                end else begin
                    nd = first_set_from(m, (m_digit + 1) % 4);
                    if (nd <= m_digit) begin
                        m_frame = d;
                        m_fd    = 1;
                    end
                    m_digit = nd;
                    m_pos   = 0;
                end
            end else begin
                m_pos++;
            end
            if (m_active) begin
                m_sel = 2'(m_digit);
                m_nib = m_frame[4*m_digit +: 4];
            end
        end
    endtask

    task automatic cyc(input bit r, input bit ru, input logic [3:0] m, input logic [15:0] d,
                       input string tag);
        exp_t e;
        rst = r; run = ru; digit_mask = m; data = d;
        model_step(r, ru, m, d);
        e.sel  = m_sel;
        e.en_n = !m_active || (m_pos < B);
        e.nib  = m_nib;
        e.fd   = m_fd;
        q.push_back(e);
        tq.push_back(tag);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                t = tq.pop_front();
                checks++;
                if ({sel, enable_n, nibble, frame_done} !== e) begin
                    errors++;
                    $display("FAIL %s @%0t: got sel=%0d enable_n=%b nibble=%h frame_done=%b, expected sel=%0d enable_n=%b nibble=%h frame_done=%b",
                             t, $time, sel, enable_n, nibble, frame_done, e.sel, e.en_n, e.nib, e.fd);
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0]  rm;
        logic [15:0] rd;
        bit          rr;
        cyc(1, 1'($urandom), 4'($urandom), 16'($urandom), "reset");
        cyc(1, 1'($urandom), 4'($urandom), 16'($urandom), "reset");

        for (int i = 0; i < 36; i++) cyc(0, 1, 4'hF, 16'hA5C3, "full_scan");

        for (int i = 0; i < 20 && !(m_active && m_digit == 1); i++)
            cyc(0, 1, 4'hF, 16'hA5C3, "coherence_pre");
        for (int i = 0; i < 24; i++) cyc(0, 1, 4'hF, 16'h1234, "coherence");

        for (int i = 0; i < 24; i++) cyc(0, 1, 4'b1010, 16'h1234, "mask_1010");
        for (int i = 0; i < 16; i++) cyc(0, 1, 4'b0100, 16'h9876, "mask_0100");

        for (int i = 0; i < 20 && !(m_active && m_pos == 2); i++)
            cyc(0, 1, 4'hF, 16'h9876, "stop_pre");
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'hF, 16'h9876, "stop_run");
        for (int i = 0; i < 6; i++) cyc(0, 1, 4'h0, 16'h4321, "mask_zero_idle");
        for (int i = 0; i < 6; i++) cyc(0, 1, 4'hF, 16'h4321, "restart");
        for (int i = 0; i < 8; i++) cyc(0, 1, 4'h0, 16'h4321, "mask_clear");

        for (int i = 0; i < 40 && !(m_active && m_digit == 2 && m_pos == 3); i++)
            cyc(0, 1, 4'hF, 16'hBEEF, "midreset_pre");
        cyc(1, 1, 4'hF, 16'hBEEF, "midreset");
        for (int i = 0; i < 12; i++) cyc(0, 1, 4'b0110, 16'hCAFE, "post_reset");

        rm = 4'hF; rd = 16'h0; rr = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) rm = 4'($urandom);
            if ($urandom_range(0, 9) == 0)  rd = 16'($urandom);
            if ($urandom_range(0, 15) == 0) rr = ($urandom_range(0, 3) != 0);
            cyc(($urandom_range(0, 199) == 0), rr, rm, rd, "random");
        end

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
